ohm_div_mc: RTL and testbench

- Multi-channel, parametrised igniter-resistance calculator: R = |V| * SCALE[ch] / max(1, |I|).
- Uses a radix-4 restoring sequential divider (2 quotient bits per cycle) with valid/ready handshakes on input and output.
- Each channel has a runtime-writable scale register for calibration.
- Result is clipped to 6.5 ohms format in ADC encoding and carries status flags.
- Sits between the ADC sample path and the igniter_resistance averaging/tone logic, shared by all igniter channels.

---
 rtl/ohm_pkg.sv | 36 +++
 rtl/radix4_div_step.sv | 51 +++++
 rtl/ohm_div_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_ohm_div_mc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ohm_pkg.sv
// Shared definitions for the igniter resistance calculator.
// Latency: none (package only).
// Backpressure: n/a.
//
// Holds the ADC-format helpers, the status flag bit positions, the
// calculator FSM state type and the lab-calibrated default scale.
package ohm_pkg;

  // 205 dn/A current gain, 0.2005 V/dn voltage gain, scaled by 2^10.
  localparam int unsigned SCALE_DEFAULT_LCS = 42089;

  // Bit positions inside out_flags.
  localparam int FLG_LOWCUR = 0;
  localparam int FLG_SAT    = 1;
  localparam int FLG_VNEG   = 2;
  localparam int FLG_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    PACK,
    HOLD
  } state_t;

  // The ADC word carries its sign in the top bit.
  function automatic int unsigned adc_sign_bit(input int unsigned adc_w);
    return adc_w - 1;
  endfunction

  // The ADC magnitude field is stored inverted: magnitude = field XOR mask.
  function automatic logic [31:0] adc_mag_mask(input int unsigned adc_w);
    return (32'h1 << (adc_w - 1)) - 32'h1;
  endfunction

endpackage

// File: rtl/radix4_div_step.sv
// One radix-4 restoring division step: trial-subtract 3d/2d/1d, keep the largest fit.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   rem      partial remainder from the previous step (always < divisor)
//   dig      next two numerator bits, MSB first
//   d1/d2/d3 divisor multiples 1x, 2x, 3x
//   rem_nxt  remainder after this step
//   qdig     two quotient bits produced by this step
module radix4_div_step #(
  parameter int RW = 14
) (
  input  logic [RW-1:0] rem,
  input  logic [1:0]    dig,
  input  logic [RW-1:0] d1,
  input  logic [RW-1:0] d2,
  input  logic [RW-1:0] d3,
  output logic [RW-1:0] rem_nxt,
  output logic [1:0]    qdig
);

  logic [RW-1:0] pr;
  logic [RW:0]   t1;
  logic [RW:0]   t2;
  logic [RW:0]   t3;

  // rem < divisor, so its top two bits are zero and the shift loses nothing.
  assign pr = (rem << 2) | {{(RW-2){1'b0}}, dig};

  // One extra bit on each trial acts as the borrow / negative indicator.
  assign t1 = {1'b0, pr} - {1'b0, d1};
  assign t2 = {1'b0, pr} - {1'b0, d2};
  assign t3 = {1'b0, pr} - {1'b0, d3};

  always_comb begin
    qdig    = 2'd0;
    rem_nxt = pr;
    if (!t3[RW]) begin
      qdig    = 2'd3;
      rem_nxt = t3[RW-1:0];
    end else if (!t2[RW]) begin
      qdig    = 2'd2;
      rem_nxt = t2[RW-1:0];
    end else if (!t1[RW]) begin
      qdig    = 2'd1;
      rem_nxt = t1[RW-1:0];
    end
  end

endmodule

// File: rtl/ohm_div_mc.sv
// Multi-channel igniter resistance R = |V| * scale[ch] / max(1,|I|), clipped, in ADC format.
// Latency: accept edge + (Q_W/2 + 2) edges to out_valid (17 at defaults), fixed.
// Backpressure: one sample in flight; in_ready low from accept until the cycle after out handshake.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           sample handshake; in_ch, v_in, i_in the sample
//   cfg_we/cfg_ch/cfg_scale     per-channel scale register write port (any state)
//   out_valid/out_ready         result handshake; out_ch, r_out, out_flags the result
module ohm_div_mc
  import ohm_pkg::*;
#(
  parameter int          NCH           = 4,
  parameter int          ADC_W         = 12,
  parameter int          SCALE_W       = 16,
  parameter int unsigned SCALE_DEFAULT = SCALE_DEFAULT_LCS,
  parameter int          PRE_SHIFT     = 3,
  parameter int          Q_FRAC        = 13,
  parameter int          OUT_FRAC      = 5,
  parameter int          I_MIN         = 33,
  localparam int         CH_W          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH_W-1:0]    in_ch,
  input  logic [ADC_W-1:0]   v_in,
  input  logic [ADC_W-1:0]   i_in,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [SCALE_W-1:0] cfg_scale,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [ADC_W-1:0]   r_out,
  output logic [2:0]         out_flags
);

  localparam int          MAG_W     = ADC_W - 1;
  localparam int unsigned SIGN      = adc_sign_bit(ADC_W);
  localparam int          N_W       = MAG_W + SCALE_W;
  // Q_W must be even so the radix-4 loop consumes it exactly.
  localparam int          Q_W       = N_W + PRE_SHIFT;
  localparam int          RW        = MAG_W + 3;
  localparam int          DIV_STEPS = Q_W / 2;
  localparam int          SC_W      = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
  localparam int          SH        = Q_FRAC - OUT_FRAC;

  localparam logic [MAG_W-1:0]   MAG_MASK  = MAG_W'(adc_mag_mask(ADC_W));
  localparam logic [SCALE_W-1:0] SCALE_RST = SCALE_W'(SCALE_DEFAULT);

  state_t state;
  state_t state_nxt;

  // Calibration registers and the value presented for the sample's channel.
  logic [SCALE_W-1:0] scale_reg [NCH];
  logic [SCALE_W-1:0] scale_sel;

  // Captured sample.
  logic [CH_W-1:0]    ch_q;
  logic [MAG_W-1:0]   v_mag_q;
  logic [MAG_W-1:0]   i_mag_q;
  logic [SCALE_W-1:0] cap_scale;
  logic               vneg_q;

  // Divider state.
  logic [Q_W-1:0]     num_sr;
  logic [Q_W-1:0]     quo;
  logic [RW-1:0]      rem;
  logic [RW-1:0]      d1;
  logic [RW-1:0]      d2;
  logic [RW-1:0]      d3;
  logic [SC_W-1:0]    step_cnt;
  logic [RW-1:0]      step_rem;
  logic [1:0]         step_q;

  // Combinational helpers.
  logic [MAG_W-1:0]   v_mag_in;
  logic [MAG_W-1:0]   i_raw_mag;
  logic [MAG_W-1:0]   i_mag_in;
  logic [N_W-1:0]     prod;
  logic [RW-1:0]      i_ext;
  logic               sat_c;
  logic               lowcur_c;
  logic [MAG_W-1:0]   pack_mag;
  logic [2:0]         pack_flags;
  logic               accept;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        accept   = in_valid && !reset;
        if (in_valid) begin
          state_nxt = MUL;
        end
      end
      MUL:  state_nxt = DIV;
      DIV: begin
        if (step_cnt == SC_W'(DIV_STEPS - 1)) begin
          state_nxt = PACK;
        end
      end
      PACK: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- scale regs
  // Channels that do not exist match no register, so such writes drop out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        scale_reg[k] <= SCALE_RST;
      end
    end else if (cfg_we) begin
      for (int k = 0; k < NCH; k++) begin
        if (cfg_ch == CH_W'(k)) begin
          scale_reg[k] <= cfg_scale;
        end
      end
    end
  end

  // Reading before the write lands gives the old value on a same-cycle write.
  always_comb begin
    scale_sel = SCALE_RST;
    for (int k = 0; k < NCH; k++) begin
      if (in_ch == CH_W'(k)) begin
        scale_sel = scale_reg[k];
      end
    end
  end

  // --------------------------------------------------------- input decode
  // Negative voltage reads as zero; negative or zero current reads as one,
  // which keeps the divider well-defined and trips lowcur downstream.
  assign v_mag_in  = v_in[SIGN] ? '0 : (v_in[MAG_W-1:0] ^ MAG_MASK);
  assign i_raw_mag = i_in[MAG_W-1:0] ^ MAG_MASK;
  assign i_mag_in  = (i_in[SIGN] || (i_raw_mag == '0)) ? MAG_W'(1) : i_raw_mag;

  assign prod  = N_W'(v_mag_q) * N_W'(cap_scale);
  assign i_ext = RW'(i_mag_q);

  // ------------------------------------------------------------- divider
  radix4_div_step #(
    .RW (RW)
  ) u_step (
    .rem     (rem),
    .dig     (num_sr[Q_W-1 -: 2]),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .rem_nxt (step_rem),
    .qdig    (step_q)
  );

  // ---------------------------------------------------------------- pack
  always_comb begin
    sat_c    = |(quo >> (SH + MAG_W));
    lowcur_c = (i_mag_q < MAG_W'(I_MIN));
    pack_mag = quo[SH +: MAG_W];
    if (sat_c) begin
      pack_mag = '1;
    end
    if (lowcur_c) begin
      pack_mag = '0;
    end
    pack_flags             = 3'b000;
    pack_flags[FLG_LOWCUR] = lowcur_c;
    pack_flags[FLG_SAT]    = sat_c && !lowcur_c;
    pack_flags[FLG_VNEG]   = vneg_q;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q      <= '0;
      v_mag_q   <= '0;
      i_mag_q   <= '0;
      cap_scale <= '0;
      vneg_q    <= 1'b0;
      num_sr    <= '0;
      quo       <= '0;
      rem       <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      step_cnt  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      r_out     <= {1'b0, MAG_MASK};
      out_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ch_q      <= in_ch;
            v_mag_q   <= v_mag_in;
            i_mag_q   <= i_mag_in;
            cap_scale <= scale_sel;
            vneg_q    <= v_in[SIGN];
          end
        end
        MUL: begin
          num_sr   <= {prod, {PRE_SHIFT{1'b0}}};
          quo      <= '0;
          rem      <= '0;
          d1       <= i_ext;
          d2       <= i_ext << 1;
          d3       <= i_ext + (i_ext << 1);
          step_cnt <= '0;
        end
        DIV: begin
          num_sr   <= num_sr << 2;
          quo      <= {quo[Q_W-3:0], step_q};
          rem      <= step_rem;
          step_cnt <= step_cnt + SC_W'(1);
        end
        PACK: begin
          r_out     <= {1'b0, pack_mag ^ MAG_MASK};
          out_ch    <= ch_q;
          out_flags <= pack_flags;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ohm_div_mc.sv
module tb_ohm_div_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [11:0] v_in;
  logic [11:0] i_in;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_scale;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
  logic [11:0] r_out;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  ohm_div_mc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .v_in      (v_in),
    .i_in      (i_in),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_scale (cfg_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .r_out     (r_out),
    .out_flags (out_flags)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] r;
    logic [2:0]  fl;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int unsigned mscale[4];
  bit          bp = 1'b0;
  bit          seen = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expire(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Resistance from first principles: {flags[2:0], r_out[11:0]}.
  function automatic logic [14:0] model(input logic [11:0] v, input logic [11:0] i,
                                        input int unsigned sc);
    longint vm, im, q, mag;
    logic   sat, low, vneg;
    vneg = v[11];
    vm   = vneg ? 0 : 2047 - longint'(v[10:0]);
    im   = i[11] ? 1 : 2047 - longint'(i[10:0]);
    if (im == 0) im = 1;
    q    = (vm * longint'(sc) * 8) / im;
    mag  = q / 256;
    sat  = 1'b0;
    low  = 1'b0;
    if (mag > 2047) begin
      mag = 2047;
      sat = 1'b1;
    end
    if (im < 33) begin
      mag = 0;
      low = 1'b1;
      sat = 1'b0;
    end
    return {vneg, sat, low, 12'(2047 - mag)};
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [1:0] ch, input logic [11:0] v, input logic [11:0] i,
                      input bit do_cfg, input logic [1:0] cch, input logic [15:0] csc);
    int          t;
    logic [14:0] r;
    t = 0;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      if (bp) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (!in_ready) begin
      expire("send_wait_in_ready");
      return;
    end
    in_valid = 1'b1;
    in_ch    = ch;
    v_in     = v;
    i_in     = i;
    r = model(v, i, mscale[ch]);
    expq.push_back('{ch, r[11:0], r[14:12], cyc + 1});
    if (do_cfg) begin
      cfg_we    = 1'b1;
      cfg_ch    = cch;
      cfg_scale = csc;
      mscale[cch] = csc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] sc);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_scale = sc;
    mscale[ch] = sc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(expq.size() == 0 && !out_valid && in_ready) && t < 400) begin
      @(negedge clk);
      if (bp) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (t >= 400) expire("wait_idle");
  endtask

  // Scoreboard monitor: compares on the first cycle each result is presented.
  always @(negedge clk) begin
    if (reset) begin
      seen <= 1'b0;
    end else if (!out_valid) begin
      seen <= 1'b0;
    end else if (!seen) begin
      seen <= 1'b1;
      if (expq.size() == 0) begin
        expire("unexpected_out_valid");
      end else begin
        mon_e = expq.pop_front();
        check("latency", cyc - mon_e.acc, 17);
        check("r_out", r_out, mon_e.r);
        check("out_ch", out_ch, mon_e.ch);
        check("out_flags", out_flags, mon_e.fl);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [1:0]  rch;
    logic [11:0] rv, ri;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    v_in      = '0;
    i_in      = '0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_scale = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) mscale[k] = 42089;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_r_out", r_out, 12'h7FF);
    check("rst_out_ch", out_ch, 0);
    check("rst_flags", out_flags, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Nominal sample.
    send(2'd0, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    check("busy_in_ready", in_ready, 0);
    wait_idle();
    check("t1_r_out", r_out, 12'h57E);
    check("t1_flags", out_flags, 3'b000);

    // Recalibrated channel.
    cfg_write(2'd2, 16'd21044);
    send(2'd2, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("t2_r_out", r_out, 12'h6BF);
    check("t2_out_ch", out_ch, 2);
    send(2'd0, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("t2_ch0_r_out", r_out, 12'h57E);

    // Saturation at the lowcur threshold, then lowcur just below.
    send(2'd0, 12'h000, 12'h7DE, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("sat_r_out", r_out, 12'h000);
    check("sat_flags", out_flags, 3'b010);
    send(2'd0, 12'h000, 12'h7EB, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("low_r_out", r_out, 12'h7FF);
    check("low_flags", out_flags, 3'b001);

    // Negative voltage, negative current.
    send(2'd1, 12'h800, 12'h732, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("vneg_r_out", r_out, 12'h7FF);
    check("vneg_flags", out_flags, 3'b100);
    send(2'd1, 12'h79B, 12'h900, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("ineg_r_out", r_out, 12'h7FF);
    check("ineg_flags", out_flags, 3'b001);

    // Scale write on the same cycle as an accept on that channel.
    send(2'd0, 12'h79B, 12'h732, 1'b1, 2'd0, 16'd21044);
    wait_idle();
    check("coinc_old_r_out", r_out, 12'h57E);
    send(2'd0, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("coinc_new_r_out", r_out, 12'h6BF);
    cfg_write(2'd0, 16'd42089);

    // Output backpressure.
    out_ready = 1'b0;
    send(2'd1, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) expire("hold_wait_out_valid");
    in_valid = 1'b1;
    in_ch    = 2'd3;
    v_in     = 12'h123;
    i_in     = 12'h456;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_r_out", r_out, 12'h57E);
      check("hold_out_ch", out_ch, 1);
      check("hold_flags", out_flags, 0);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("hs_r_out_kept", r_out, 12'h57E);

    // Reset in the middle of a division.
    send(2'd2, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    if (expq.size() > 0) expq.delete(expq.size() - 1);
    for (int k = 0; k < 4; k++) mscale[k] = 42089;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_r_out", r_out, 12'h7FF);
    check("midrst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_post_in_ready", in_ready, 1);
    send(2'd2, 12'h79B, 12'h732, 1'b0, 2'd0, 16'd0);
    wait_idle();
    check("midrst_scale_r_out", r_out, 12'h57E);
    check("midrst_out_ch", out_ch, 2);

    // Random traffic with random backpressure and calibration writes.
    bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rch = 2'($urandom_range(0, 3));
      rv  = 12'($urandom);
      if ($urandom_range(0, 3) == 0) ri = 12'h7FF - 12'($urandom_range(0, 40));
      else                           ri = 12'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        send(rch, rv, ri, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)));
      end else begin
        send(rch, rv, ri, 1'b0, 2'd0, 16'd0);
      end
      if ($urandom_range(0, 1) == 0) begin
        cfg_write(2'($urandom_range(0, 3)), 16'($urandom_range(1, 65535)));
      end
    end
    wait_idle();
    bp = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
